// File: rtl/prach_hb3_dmux.sv
`default_nettype none
// ============================================================================
// Module   : prach_hb3_dmux
// Brief    : Per-channel polyphase pair splitter feeding the PRACH third
//            half-band decimator. Optional macro PRACH_HB3_DMUX_DROP_UNUSED_EN
//            drops channel addresses at or above NumChannelUsed.
// Revision : 1.0  initial release
// ============================================================================
module prach_hb3_dmux #(
  parameter int NumChannel     = 64,
  parameter int NumChannelUsed = 48
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] din_dq,
  input  logic        din_dv,
  input  logic [7:0]  din_chn,
  input  logic        sync_in,
  output logic [15:0] dout_dp1,
  output logic [15:0] dout_dp2,
  output logic        dout_dv,
  output logic [7:0]  dout_chn,
  output logic        sync_out
);

  logic [NumChannel-1:0] phase;
  logic [NumChannel-1:0] phase_nxt;
  logic [15:0]           store [NumChannel];
  logic                  sync_pend;

  logic [5:0]  addr;
  logic        in_range;
  logic        accept;
  logic        cur_phase;
  logic        emit;
  logic        store_wr;

  logic        s1_valid;
  logic        s1_sync;
  logic [15:0] s1_dp1;
  logic [15:0] s1_dp2;
  logic [7:0]  s1_chn;

  assign addr = din_chn[5:0];

`ifdef PRACH_HB3_DMUX_DROP_UNUSED_EN
  localparam logic [7:0] UsedLimit = 8'(NumChannelUsed);
  assign in_range = (din_chn[7:6] == 2'b00) && (din_chn < UsedLimit);
`else
  assign in_range = (din_chn[7:6] == 2'b00);
`endif

  // A coincident sync forces the beat to phase 0 before classification.
  assign accept    = din_dv & in_range;
  assign cur_phase = sync_in ? 1'b0 : phase[addr];
  assign emit      = accept & cur_phase;
  assign store_wr  = accept & ~cur_phase;

  always_comb begin
    phase_nxt = sync_in ? '0 : phase;
    if (accept) begin
      phase_nxt[addr] = ~cur_phase;
    end
  end

  // Sample store has no reset; a phase-0 write always precedes any read.
  always_ff @(posedge clk) begin
    if (store_wr) begin
      store[addr] <= din_dq;
    end
  end

  // Combinational read into the capture register, so a write in the previous
  // cycle is already visible to a back-to-back phase-1 beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= '0;
      sync_pend <= 1'b0;
      s1_valid  <= 1'b0;
      s1_sync   <= 1'b0;
      s1_dp1    <= '0;
      s1_dp2    <= '0;
      s1_chn    <= '0;
    end else begin
      phase    <= phase_nxt;
      s1_valid <= emit;
      if (sync_in) begin
        sync_pend <= 1'b1;
      end else if (emit) begin
        sync_pend <= 1'b0;
      end
      if (emit) begin
        s1_dp1  <= din_dq;
        s1_dp2  <= store[addr];
        s1_chn  <= din_chn;
        s1_sync <= sync_pend;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_dp1 <= '0;
      dout_dp2 <= '0;
      dout_dv  <= 1'b0;
      dout_chn <= '0;
      sync_out <= 1'b0;
    end else begin
      dout_dv  <= s1_valid;
      sync_out <= s1_valid & s1_sync;
      if (s1_valid) begin
        dout_dp1 <= s1_dp1;
        dout_dp2 <= s1_dp2;
        dout_chn <= s1_chn;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prach_hb3_dmux.sv
`default_nettype none
// ============================================================================
// Module   : tb_prach_hb3_dmux
// Brief    : Directed plus randomized bench for prach_hb3_dmux against a
//            pairing model (honours PRACH_HB3_DMUX_DROP_UNUSED_EN).
// Revision : 1.0  initial release
// ============================================================================
module tb_prach_hb3_dmux;

  logic        clk;
  logic        rst_n;
  logic [15:0] din_dq;
  logic        din_dv;
  logic [7:0]  din_chn;
  logic        sync_in;
  logic [15:0] dout_dp1;
  logic [15:0] dout_dp2;
  logic        dout_dv;
  logic [7:0]  dout_chn;
  logic        sync_out;

  int checks = 0;
  int errors = 0;

`ifdef PRACH_HB3_DMUX_DROP_UNUSED_EN
  localparam int Used = 48;
`else
  localparam int Used = 64;
`endif

  prach_hb3_dmux #(.NumChannel(64), .NumChannelUsed(48)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_dq   (din_dq),
    .din_dv   (din_dv),
    .din_chn  (din_chn),
    .sync_in  (sync_in),
    .dout_dp1 (dout_dp1),
    .dout_dp2 (dout_dp2),
    .dout_dv  (dout_dv),
    .dout_chn (dout_chn),
    .sync_out (sync_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a channel holding a first sample is waiting for its partner.
  logic [15:0] first [int];
  logic        spend;
  // Emission from the previous step (visible after the next edge).
  logic        p_v, p_s;
  logic [15:0] p_1, p_2;
  logic [7:0]  p_c;
  // Expected output values.
  logic        e_dv, e_sync;
  logic [15:0] e_dp1, e_dp2;
  logic [7:0]  e_chn;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    first.delete();
    spend = 1'b0;
    p_v = 1'b0; p_s = 1'b0; p_1 = '0; p_2 = '0; p_c = '0;
    e_dv = 1'b0; e_sync = 1'b0; e_dp1 = '0; e_dp2 = '0; e_chn = '0;
  endtask

  task automatic check_all();
    chk("dout_dv",  {15'd0, dout_dv},  {15'd0, e_dv});
    chk("sync_out", {15'd0, sync_out}, {15'd0, e_sync});
    chk("dout_dp1", dout_dp1, e_dp1);
    chk("dout_dp2", dout_dp2, e_dp2);
    chk("dout_chn", {8'd0, dout_chn}, {8'd0, e_chn});
  endtask

  task automatic step(input logic v, input logic [7:0] c, input logic [15:0] d, input logic s);
    logic        mv, ms;
    logic [15:0] m1, m2;
    logic [7:0]  mc;
    int          ch;
    mv = 1'b0; ms = 1'b0; m1 = '0; m2 = '0; mc = '0;
    din_dv = v; din_chn = c; din_dq = d; sync_in = s;
    ch = int'(c[5:0]);
    if (rst_n) begin
      if (s) begin
        first.delete();
        spend = 1'b1;
      end
      if (v && c[7:6] == 2'b00 && ch < Used) begin
        if (first.exists(ch)) begin
          mv = 1'b1; m1 = d; m2 = first[ch]; mc = c; ms = spend;
          spend = 1'b0;
          first.delete(ch);
        end else begin
          first[ch] = d;
        end
      end
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      e_dv   = p_v;
      e_sync = p_v & p_s;
      if (p_v) begin
        e_dp1 = p_1; e_dp2 = p_2; e_chn = p_c;
      end
      p_v = mv; p_s = ms; p_1 = m1; p_2 = m2; p_c = mc;
    end
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, 16'd0, 1'b0);
  endtask

  initial begin
    logic        rv, rs;
    logic [7:0]  rc;
    rst_n = 1'b0;
    din_dq = '0; din_dv = 1'b0; din_chn = '0; sync_in = 1'b0;
    model_reset();

    // Reset state
    idle(2);
    rst_n = 1'b1;

    // Sync then two round-robin passes over the active channels
    step(1'b0, 8'd0, 16'd0, 1'b1);
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 48; c++) step(1'b1, 8'(c), 16'(2 * k), 1'b0);
    idle(3);

    // Back-to-back beats on channel 5
    step(1'b1, 8'd5, 16'h1234, 1'b0);
    step(1'b1, 8'd5, 16'h8001, 1'b0);
    step(1'b0, 8'd0, 16'd0, 1'b0);
    chk("b2b_dv",  {15'd0, dout_dv}, 16'd1);
    chk("b2b_dp2", dout_dp2, 16'h1234);
    chk("b2b_dp1", dout_dp1, 16'h8001);
    idle(2);

    // Sync coincident with a would-be phase-1 beat on channel 3
    step(1'b1, 8'd3, 16'h0AAA, 1'b0);
    idle(2);
    step(1'b1, 8'd3, 16'h0BBB, 1'b1);
    idle(2);
    chk("sync_nodv", {15'd0, dout_dv}, 16'd0);
    step(1'b1, 8'd3, 16'h0CCC, 1'b0);
    step(1'b0, 8'd0, 16'd0, 1'b0);
    chk("sync_dp2",  dout_dp2, 16'h0BBB);
    chk("sync_flag", {15'd0, sync_out}, 16'd1);
    idle(2);

    // Out-of-range channel tags interleaved with channels 0 and 5
    step(1'b1, 8'h00, 16'h1111, 1'b0);
    step(1'b1, 8'h40, 16'hDEAD, 1'b0);
    step(1'b1, 8'hC5, 16'hBEEF, 1'b0);
    step(1'b1, 8'h05, 16'h2222, 1'b0);
    step(1'b1, 8'h40, 16'hDEAD, 1'b0);
    step(1'b1, 8'h00, 16'h3333, 1'b0);
    step(1'b1, 8'hC5, 16'hBEEF, 1'b0);
    step(1'b1, 8'h05, 16'h4444, 1'b0);
    idle(3);

    // Channel 50: dropped only when the unused-channel filter is built in
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'd50, 16'(16'h5000 + i), 1'b0);
      idle(1);
    end
    idle(2);

    // Reset between the two samples of a pair
    step(1'b1, 8'd7, 16'h7777, 1'b0);
    step(1'b1, 8'd9, 16'h9999, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    idle(2);
    rst_n = 1'b1;
    step(1'b1, 8'd7, 16'h5555, 1'b0);
    idle(3);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rv = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: rc = 8'($urandom_range(0, 5));
        7:                   rc = 8'($urandom_range(0, 63));
        8:                   rc = 8'd50;
        default:             rc = 8'($urandom_range(0, 255));
      endcase
      // Keep sync away from a pair already in flight so its owner is unambiguous
      rs = ($urandom_range(0, 40) == 0) && !p_v;
      step(rv, rc, 16'($urandom), rs);
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
